// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Runs one req/ack transaction per load/store on the data-memory bus. It holds
// the pipeline until the access completes or times out. It then emits one
// registered writeback packet per instruction. Non-memory instructions pass
// through with one cycle of latency.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_load_en,
    input  logic        ex_store_en,
    input  logic        ex_write_reg,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_res,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_write_reg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Bus request registers; they also act as the latched address/data.
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;

    // Instruction context captured on accept, consumed on completion.
    logic [4:0]  lat_rd_reg, lat_rd_next;
    logic        lat_wr_reg, lat_wr_next;
    logic        lat_load_reg, lat_load_next;

    // Writeback packet and error pulse.
    logic        wb_valid_reg, wb_valid_next;
    logic        wb_write_reg_reg, wb_write_reg_next;
    logic [4:0]  wb_rd_reg, wb_rd_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic        mem_err_reg, mem_err_next;

    logic        stall_comb;
    logic        mem_op;
    logic        misaligned;
    logic        cnt_last;

    assign mem_op     = ex_valid & (ex_load_en | ex_store_en);
    assign misaligned = (ex_res[1:0] != 2'b00);
    assign cnt_last   = (cnt_reg == CNT_LAST);

    // Next-state, bus request, writeback packet and stall decode.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        mem_req_next      = mem_req_reg;
        mem_we_next       = mem_we_reg;
        mem_addr_next     = mem_addr_reg;
        mem_wdata_next    = mem_wdata_reg;
        lat_rd_next       = lat_rd_reg;
        lat_wr_next       = lat_wr_reg;
        lat_load_next     = lat_load_reg;
        wb_valid_next     = 1'b0;
        wb_write_reg_next = wb_write_reg_reg;
        wb_rd_next        = wb_rd_reg;
        wb_data_next      = wb_data_reg;
        mem_err_next      = 1'b0;
        stall_comb        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!mem_op) begin
                        // Plain ALU result: straight through to WB.
                        wb_valid_next     = 1'b1;
                        wb_write_reg_next = ex_write_reg;
                        wb_rd_next        = ex_rd;
                        wb_data_next      = ex_res;
                    end else if (misaligned) begin
                        // Rejected without touching the bus; retire with no write.
                        wb_valid_next     = 1'b1;
                        wb_write_reg_next = 1'b0;
                        wb_rd_next        = ex_rd;
                        wb_data_next      = ex_res;
                        mem_err_next      = 1'b1;
                    end else begin
                        // Accept: hold execute so it keeps presenting this op.
                        stall_comb     = 1'b1;
                        mem_req_next   = 1'b1;
                        mem_we_next    = ex_store_en;
                        mem_addr_next  = ex_res;
                        mem_wdata_next = ex_wdata;
                        lat_rd_next    = ex_rd;
                        lat_wr_next    = ex_write_reg;
                        lat_load_next  = ~ex_store_en;
                        cnt_next       = '0;
                        state_next     = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Release execute on the ack cycle or on the last timeout cycle.
                stall_comb = ~mem_ack & ~cnt_last;
                if (mem_ack) begin
                    mem_req_next      = 1'b0;
                    state_next        = ST_IDLE;
                    wb_valid_next     = 1'b1;
                    wb_write_reg_next = lat_wr_reg & lat_load_reg;
                    wb_rd_next        = lat_rd_reg;
                    wb_data_next      = lat_load_reg ? mem_rdata : mem_addr_reg;
                end else if (cnt_last) begin
                    // Abandon the access; the instruction retires with an error.
                    mem_req_next      = 1'b0;
                    state_next        = ST_IDLE;
                    wb_valid_next     = 1'b1;
                    wb_write_reg_next = 1'b0;
                    wb_rd_next        = lat_rd_reg;
                    wb_data_next      = mem_addr_reg;
                    mem_err_next      = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    // State, bus and writeback registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            mem_req_reg      <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            lat_rd_reg       <= '0;
            lat_wr_reg       <= 1'b0;
            lat_load_reg     <= 1'b0;
            wb_valid_reg     <= 1'b0;
            wb_write_reg_reg <= 1'b0;
            wb_rd_reg        <= '0;
            wb_data_reg      <= '0;
            mem_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            mem_req_reg      <= mem_req_next;
            mem_we_reg       <= mem_we_next;
            mem_addr_reg     <= mem_addr_next;
            mem_wdata_reg    <= mem_wdata_next;
            lat_rd_reg       <= lat_rd_next;
            lat_wr_reg       <= lat_wr_next;
            lat_load_reg     <= lat_load_next;
            wb_valid_reg     <= wb_valid_next;
            wb_write_reg_reg <= wb_write_reg_next;
            wb_rd_reg        <= wb_rd_next;
            wb_data_reg      <= wb_data_next;
            mem_err_reg      <= mem_err_next;
        end
    end

    // Stall is forced low while in reset so upstream never freezes on reset.
    assign stall        = stall_comb & rst_n;
    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_write_reg = wb_write_reg_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;
    assign mem_err      = mem_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed per-cycle vector table plus hand-written sequences
// for timeout and reset-during-WAIT, for mem_stage with TIMEOUT=4.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_load_en, ex_store_en, ex_write_reg;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res, ex_wdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_write_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_load_en(ex_load_en), .ex_store_en(ex_store_en),
        .ex_write_reg(ex_write_reg), .ex_rd(ex_rd), .ex_res(ex_res), .ex_wdata(ex_wdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_write_reg(wb_write_reg), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    // One clock cycle: inputs applied, then expectations sampled mid-cycle.
    typedef struct {
        logic        v, ld, st, wr;
        logic [4:0]  rd;
        logic [31:0] res, wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_err, e_wbv, e_wbwr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        logic v, logic ld, logic st, logic wr, logic [4:0] rd, logic [31:0] res,
        logic [31:0] wd, logic ack, logic [31:0] rdata,
        logic e_stall, logic e_req, logic e_we, logic [31:0] e_addr, logic [31:0] e_wdata,
        logic e_err, logic e_wbv, logic e_wbwr, logic [4:0] e_rd, logic [31:0] e_data,
        logic chk_data);
        vec_t t;
        t.v = v; t.ld = ld; t.st = st; t.wr = wr; t.rd = rd; t.res = res; t.wd = wd;
        t.ack = ack; t.rdata = rdata;
        t.e_stall = e_stall; t.e_req = e_req; t.e_we = e_we; t.e_addr = e_addr;
        t.e_wdata = e_wdata; t.e_err = e_err; t.e_wbv = e_wbv; t.e_wbwr = e_wbwr;
        t.e_rd = e_rd; t.e_data = e_data; t.chk_data = chk_data;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic wr,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] wd,
                         input logic ack, input logic [31:0] rdata);
        ex_valid = v; ex_load_en = ld; ex_store_en = st; ex_write_reg = wr;
        ex_rd = rd; ex_res = res; ex_wdata = wd; mem_ack = ack; mem_rdata = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int req_cycles;

    initial begin
        // ---------------- vector table ----------------
        //                 v  ld st wr rd  res           wd            ack rdata
        //                 stall req we addr wdata err wbv wbwr rd data chk
        // idle bubble
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 0,0,0,0,0,0));
        // ALU op, rd=5
        vecs.push_back(mkv(1,0,0,1,5,32'h1234,32'h0,0,32'h0,        0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 0,1,1,5,32'h1234,1));
        // load 0x100, ack in 3rd WAIT cycle
        vecs.push_back(mkv(1,1,0,1,7,32'h100,32'h0,0,32'h0,         1,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(1,1,0,1,7,32'h100,32'h0,0,32'h0,         1,1,0,32'h100,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(1,1,0,1,7,32'h100,32'h0,0,32'h0,         1,1,0,32'h100,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(1,1,0,1,7,32'h100,32'h0,1,32'hDEADBEEF,  0,1,0,32'h100,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 0,1,1,7,32'hDEADBEEF,1));
        // store 0x200, ack first WAIT cycle, then back-to-back store 0x204
        vecs.push_back(mkv(1,0,1,0,3,32'h200,32'hCAFEF00D,0,32'h0,  1,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(1,0,1,0,3,32'h200,32'hCAFEF00D,1,32'h55555555, 0,1,1,32'h200,32'hCAFEF00D, 0,0,0,0,0,0));
        vecs.push_back(mkv(1,0,1,0,4,32'h204,32'h11112222,0,32'h0,  1,0,0,0,0, 0,1,0,3,32'h200,1));
        vecs.push_back(mkv(1,0,1,0,4,32'h204,32'h11112222,1,32'h0,  0,1,1,32'h204,32'h11112222, 0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 0,1,0,4,32'h204,1));
        // misaligned load
        vecs.push_back(mkv(1,1,0,1,9,32'h102,32'h0,0,32'h0,         0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 1,1,0,9,0,0));
        // stray ack while idle is ignored
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,1,32'h12345678,    0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 0,0,0,0,0,0));
        // both enables: treated as store
        vecs.push_back(mkv(1,1,1,1,2,32'h300,32'hA5A5A5A5,0,32'h0,  1,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mkv(1,1,1,1,2,32'h300,32'hA5A5A5A5,1,32'h77, 0,1,1,32'h300,32'hA5A5A5A5, 0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,32'h0,32'h0,0,32'h0,           0,0,0,0,0, 0,1,0,2,32'h300,1));

        // ---------------- reset state ----------------
        drive(0,0,0,0,0,0,0,0,0);
        rst_n = 1'b0;
        #12;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_wbwr", 32'(wb_write_reg), 0);
        chk("rst_wbrd", 32'(wb_rd), 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_err", 32'(mem_err), 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---------------- table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].wr, vecs[i].rd,
                  vecs[i].res, vecs[i].wd, vecs[i].ack, vecs[i].rdata);
            #2;
            $display("vec %0d: v=%b ld=%b st=%b ack=%b | stall=%b req=%b we=%b addr=%h wbv=%b wbwr=%b rd=%0d data=%h err=%b",
                     i, ex_valid, ex_load_en, ex_store_en, mem_ack, stall, mem_req, mem_we,
                     mem_addr, wb_valid, wb_write_reg, wb_rd, wb_data, mem_err);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_err", i), 32'(mem_err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_wbv", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
                chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
                if (vecs[i].e_we)
                    chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            if (vecs[i].e_wbv) begin
                chk($sformatf("vec%0d_wbwr", i), 32'(wb_write_reg), 32'(vecs[i].e_wbwr));
                chk($sformatf("vec%0d_wbrd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
                if (vecs[i].chk_data)
                    chk($sformatf("vec%0d_wbdata", i), wb_data, vecs[i].e_data);
            end
            next_cycle();
        end

        // ---------------- timeout: load, never acked ----------------
        req_cycles = 0;
        drive(1,1,0,1,6,32'h400,0,0,0);
        #2;
        chk("to_accept_stall", 32'(stall), 1);
        chk("to_accept_req", 32'(mem_req), 0);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            #1;
            if (mem_req) req_cycles++;
            if (i < 4) begin
                chk($sformatf("to_wait%0d_req", i), 32'(mem_req), 1);
                chk($sformatf("to_wait%0d_stall", i), 32'(stall), (i < 3) ? 32'd1 : 32'd0);
            end
            if (i == 4) begin
                chk("to_err", 32'(mem_err), 1);
                chk("to_wbv", 32'(wb_valid), 1);
                chk("to_wbwr", 32'(wb_write_reg), 0);
                chk("to_wbrd", 32'(wb_rd), 6);
                chk("to_stall", 32'(stall), 0);
            end
            if (i == 5) chk("to_err_pulse", 32'(mem_err), 0);
            $display("timeout cycle %0d: req=%b stall=%b err=%b wbv=%b", i, mem_req, stall, mem_err, wb_valid);
            if (i == 3) drive(0,0,0,0,0,0,0,0,0);
            next_cycle();
        end
        chk("to_req_cycles", 32'(req_cycles), 4);

        // ---------------- reset during 2nd WAIT cycle ----------------
        drive(1,1,0,1,8,32'h500,0,0,0);
        next_cycle();              // accept edge
        next_cycle();              // now in 2nd WAIT cycle
        #1;
        chk("rw_pre_req", 32'(mem_req), 1);
        drive(0,0,0,0,0,0,0,0,0);
        rst_n = 1'b0;
        #1;
        chk("rw_req", 32'(mem_req), 0);
        chk("rw_stall", 32'(stall), 0);
        chk("rw_wbv", 32'(wb_valid), 0);
        $display("reset in WAIT: req=%b stall=%b wbv=%b", mem_req, stall, wb_valid);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        #1;
        chk("rw_post_wbv", 32'(wb_valid), 0);
        chk("rw_post_req", 32'(mem_req), 0);
        drive(1,0,0,1,10,32'hABCD,0,0,0);
        #1;
        chk("rw_alu_stall", 32'(stall), 0);
        next_cycle();
        drive(0,0,0,0,0,0,0,0,0);
        #1;
        chk("rw_alu_wbv", 32'(wb_valid), 1);
        chk("rw_alu_wbrd", 32'(wb_rd), 10);
        chk("rw_alu_wbdata", wb_data, 32'hABCD);
        chk("rw_alu_wbwr", 32'(wb_write_reg), 1);
        $display("post-reset ALU: wbv=%b rd=%0d data=%h", wb_valid, wb_rd, wb_data);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
